// File: rtl/logic2_test_pkg.sv
// Shared types and constants for the logic2 fault-injection BIST controller.
package logic2_test_pkg;

  localparam int VEC_IDX_W = 4;

  localparam logic [15:0] LOGIC2_GOLDEN_Y = 16'hFF30;
  localparam logic [15:0] LOGIC2_GOLDEN_Z = 16'h050F;

  typedef logic [VEC_IDX_W-1:0] vec_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SAMPLE,
    ST_DONE
  } bist_state_e;

endpackage

// File: rtl/logic2_bist_if.sv
// Control, result and DUT stimulus/response bundle of the logic2 BIST controller.
interface logic2_bist_if;

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic [4:0]                  fail_count;
  logic [15:0]                 fail_map;
  logic                        first_fail_vld;
  logic2_test_pkg::vec_idx_t   first_fail_idx;
  logic                        dut_a;
  logic                        dut_b;
  logic                        dut_c;
  logic                        dut_e;
  logic                        dut_y;
  logic                        dut_z;

  modport master (
    input  start, dut_y, dut_z,
    output busy, done, pass, fail_count, fail_map, first_fail_vld, first_fail_idx,
    output dut_a, dut_b, dut_c, dut_e
  );

  modport slave (
    output start, dut_y, dut_z,
    input  busy, done, pass, fail_count, fail_map, first_fail_vld, first_fail_idx,
    input  dut_a, dut_b, dut_c, dut_e
  );

endinterface

// File: rtl/logic2_bist_resp.sv
// Response checker: compares each sampled DUT output pair against the golden
// tables and accumulates the fail count, fail map, first failure and verdict.
module logic2_bist_resp
  import logic2_test_pkg::*;
#(
  parameter logic [15:0] GOLDEN_Y = LOGIC2_GOLDEN_Y,
  parameter logic [15:0] GOLDEN_Z = LOGIC2_GOLDEN_Z
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        sample_en,
  input  logic        finish,
  input  vec_idx_t    idx,
  input  logic        dut_y,
  input  logic        dut_z,
  output logic        mismatch,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [15:0] fail_map,
  output logic        first_fail_vld,
  output vec_idx_t    first_fail_idx
);

  logic        pass_q, pass_d;
  logic [4:0]  fail_count_q, fail_count_d;
  logic [15:0] fail_map_q, fail_map_d;
  logic        first_fail_vld_q, first_fail_vld_d;
  vec_idx_t    first_fail_idx_q, first_fail_idx_d;

  // Raw compare of the current vector; the controller decides when it counts.
  assign mismatch = (dut_y != GOLDEN_Y[idx]) || (dut_z != GOLDEN_Z[idx]);

  always_comb begin
    pass_d           = pass_q;
    fail_count_d     = fail_count_q;
    fail_map_d       = fail_map_q;
    first_fail_vld_d = first_fail_vld_q;
    first_fail_idx_d = first_fail_idx_q;

    if (clear) begin
      pass_d           = 1'b0;
      fail_count_d     = 5'd0;
      fail_map_d       = 16'h0000;
      first_fail_vld_d = 1'b0;
      first_fail_idx_d = '0;
    end else if (sample_en) begin
      if (mismatch) begin
        fail_map_d[idx] = 1'b1;
        fail_count_d    = fail_count_q + 5'd1;
        if (!first_fail_vld_q) begin
          first_fail_vld_d = 1'b1;
          first_fail_idx_d = idx;
        end
      end
      // Verdict includes the vector being sampled on the final edge.
      if (finish) begin
        pass_d = (fail_count_d == 5'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q           <= 1'b0;
      fail_count_q     <= 5'd0;
      fail_map_q       <= 16'h0000;
      first_fail_vld_q <= 1'b0;
      first_fail_idx_q <= '0;
    end else begin
      pass_q           <= pass_d;
      fail_count_q     <= fail_count_d;
      fail_map_q       <= fail_map_d;
      first_fail_vld_q <= first_fail_vld_d;
      first_fail_idx_q <= first_fail_idx_d;
    end
  end

  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign fail_map       = fail_map_q;
  assign first_fail_vld = first_fail_vld_q;
  assign first_fail_idx = first_fail_idx_q;

endmodule

// File: rtl/logic2_bist.sv
// BIST controller top: walks all 16 input vectors onto the logic2 DUT, holds
// each for a settle window and hands the sample to the response checker.
module logic2_bist
  import logic2_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] GOLDEN_Y      = LOGIC2_GOLDEN_Y,
  parameter logic [15:0] GOLDEN_Z      = LOGIC2_GOLDEN_Z,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  logic2_bist_if.master   bus
);

  localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES);
  localparam bit         HAS_SETTLE = (SETTLE_CYCLES != 0);

  bist_state_e state_q, state_d;
  vec_idx_t    idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        clear;
  logic        sample_en;
  logic        finish;
  logic        mismatch;

  logic        pass_w;
  logic [4:0]  fail_count_w;
  logic [15:0] fail_map_w;
  logic        first_fail_vld_w;
  vec_idx_t    first_fail_idx_w;

  // idx_q doubles as the registered stimulus, so it only moves on start or
  // on the edge leaving SAMPLE and the DUT sees a stable vector throughout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clear     = 1'b0;
    sample_en = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          clear   = 1'b1;
          idx_d   = '0;
          cnt_d   = SETTLE_LD;
          busy_d  = 1'b1;
          state_d = HAS_SETTLE ? ST_HOLD : ST_SAMPLE;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if ((idx_q == 4'd15) || (mismatch && STOP_ON_FAIL)) begin
          finish  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_LD;
          state_d = HAS_SETTLE ? ST_HOLD : ST_SAMPLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  logic2_bist_resp #(
    .GOLDEN_Y (GOLDEN_Y),
    .GOLDEN_Z (GOLDEN_Z)
  ) u_resp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .sample_en      (sample_en),
    .finish         (finish),
    .idx            (idx_q),
    .dut_y          (bus.dut_y),
    .dut_z          (bus.dut_z),
    .mismatch       (mismatch),
    .pass           (pass_w),
    .fail_count     (fail_count_w),
    .fail_map       (fail_map_w),
    .first_fail_vld (first_fail_vld_w),
    .first_fail_idx (first_fail_idx_w)
  );

  assign bus.dut_a          = idx_q[3];
  assign bus.dut_b          = idx_q[2];
  assign bus.dut_c          = idx_q[1];
  assign bus.dut_e          = idx_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_w;
  assign bus.fail_count     = fail_count_w;
  assign bus.fail_map       = fail_map_w;
  assign bus.first_fail_vld = first_fail_vld_w;
  assign bus.first_fail_idx = first_fail_idx_w;

endmodule

// File: tb/tb_logic2_bist.sv
// Bench for logic2_bist: three controller configurations, each driving a
// behavioural faulty-DUT model, checked against a vector-level reference.
module tb_logic2_bist;

  localparam logic [15:0] GY = 16'hFF30;
  localparam logic [15:0] GZ = 16'h050F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fault modes per DUT model: 0 golden xor flip mask, 1 stuck-at-0, 2 stuck-at-1
  logic        start_s [3];
  logic [1:0]  ymode   [3];
  logic [1:0]  zmode   [3];
  logic [15:0] yflip   [3];
  logic [15:0] zflip   [3];

  logic [3:0]  vec      [3];
  logic        busy_w   [3];
  logic        done_w   [3];
  logic        pass_w   [3];
  logic        vld_w    [3];
  logic [4:0]  cnt_w    [3];
  logic [15:0] map_w    [3];
  logic [3:0]  ffi_w    [3];

  logic2_bist_if bus0 ();
  logic2_bist_if bus1 ();
  logic2_bist_if bus2 ();

  logic2_bist #(.SETTLE_CYCLES(1)) u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  logic2_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic2_bist #(.SETTLE_CYCLES(0)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic modelOut(input logic [1:0] mode, input logic g, input logic f);
    case (mode)
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return g ^ f;
    endcase
  endfunction

  function automatic int settleOf(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit stopOf(input int k);
    return (k == 1);
  endfunction

  assign vec[0] = {bus0.dut_a, bus0.dut_b, bus0.dut_c, bus0.dut_e};
  assign vec[1] = {bus1.dut_a, bus1.dut_b, bus1.dut_c, bus1.dut_e};
  assign vec[2] = {bus2.dut_a, bus2.dut_b, bus2.dut_c, bus2.dut_e};

  assign bus0.dut_y = modelOut(ymode[0], GY[vec[0]], yflip[0][vec[0]]);
  assign bus0.dut_z = modelOut(zmode[0], GZ[vec[0]], zflip[0][vec[0]]);
  assign bus1.dut_y = modelOut(ymode[1], GY[vec[1]], yflip[1][vec[1]]);
  assign bus1.dut_z = modelOut(zmode[1], GZ[vec[1]], zflip[1][vec[1]]);
  assign bus2.dut_y = modelOut(ymode[2], GY[vec[2]], yflip[2][vec[2]]);
  assign bus2.dut_z = modelOut(zmode[2], GZ[vec[2]], zflip[2][vec[2]]);

  assign bus0.start = start_s[0];
  assign bus1.start = start_s[1];
  assign bus2.start = start_s[2];

  assign busy_w[0] = bus0.busy;           assign busy_w[1] = bus1.busy;           assign busy_w[2] = bus2.busy;
  assign done_w[0] = bus0.done;           assign done_w[1] = bus1.done;           assign done_w[2] = bus2.done;
  assign pass_w[0] = bus0.pass;           assign pass_w[1] = bus1.pass;           assign pass_w[2] = bus2.pass;
  assign vld_w[0]  = bus0.first_fail_vld; assign vld_w[1]  = bus1.first_fail_vld; assign vld_w[2]  = bus2.first_fail_vld;
  assign cnt_w[0]  = bus0.fail_count;     assign cnt_w[1]  = bus1.fail_count;     assign cnt_w[2]  = bus2.fail_count;
  assign map_w[0]  = bus0.fail_map;       assign map_w[1]  = bus1.fail_map;       assign map_w[2]  = bus2.fail_map;
  assign ffi_w[0]  = bus0.first_fail_idx; assign ffi_w[1]  = bus1.first_fail_idx; assign ffi_w[2]  = bus2.first_fail_idx;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  task automatic checkIdle(input int k, input string tag);
    checkOutput({tag, "_busy"}, int'(busy_w[k]), 0);
    checkOutput({tag, "_done"}, int'(done_w[k]), 0);
    checkOutput({tag, "_pass"}, int'(pass_w[k]), 0);
    checkOutput({tag, "_cnt"},  int'(cnt_w[k]),  0);
    checkOutput({tag, "_map"},  int'(map_w[k]),  0);
    checkOutput({tag, "_vld"},  int'(vld_w[k]),  0);
    checkOutput({tag, "_ffi"},  int'(ffi_w[k]),  0);
    checkOutput({tag, "_stim"}, int'(vec[k]),    0);
  endtask

  // Pulse start for one cycle; returns on the falling edge right after the accepting edge.
  task automatic applyStimulus(input int k);
    @(negedge clk);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic runCase(input int k, input string name);
    int          win;
    int          nvec;
    int          expFirst;
    bit          seen;
    logic [15:0] expMap;
    int          j;
    int          seqErr;
    int          busyErr;
    logic        fy;
    logic        fz;

    win      = 1 + settleOf(k);
    nvec     = 16;
    expFirst = 0;
    seen     = 1'b0;
    expMap   = 16'h0000;
    for (int v = 0; v < nvec; v++) begin
      fy = modelOut(ymode[k], GY[v], yflip[k][v]);
      fz = modelOut(zmode[k], GZ[v], zflip[k][v]);
      if ((fy != GY[v]) || (fz != GZ[v])) begin
        expMap[v] = 1'b1;
        if (!seen) begin
          seen     = 1'b1;
          expFirst = v;
          if (stopOf(k)) nvec = v + 1;
        end
      end
    end

    applyStimulus(k);
    checkOutput({name, "_clr_cnt"},  int'(cnt_w[k]),  0);
    checkOutput({name, "_clr_map"},  int'(map_w[k]),  0);
    checkOutput({name, "_clr_pass"}, int'(pass_w[k]), 0);

    j       = 0;
    seqErr  = 0;
    busyErr = 0;
    while (!done_w[k] && j < 400) begin
      if (vec[k] != 4'(j / win)) seqErr++;
      if (!busy_w[k]) busyErr++;
      @(negedge clk);
      j++;
    end

    checkOutput({name, "_done_edge"}, j, nvec * win);
    checkOutput({name, "_seq"},       seqErr, 0);
    checkOutput({name, "_busy_run"},  busyErr, 0);
    checkOutput({name, "_busy_end"},  int'(busy_w[k]), 0);
    checkOutput({name, "_pass"},      int'(pass_w[k]), (expMap == 16'h0000) ? 1 : 0);
    checkOutput({name, "_cnt"},       int'(cnt_w[k]),  $countones(expMap));
    checkOutput({name, "_map"},       int'(map_w[k]),  int'(expMap));
    checkOutput({name, "_vld"},       int'(vld_w[k]),  int'(seen));
    checkOutput({name, "_ffi"},       int'(ffi_w[k]),  expFirst);

    @(negedge clk);
    checkOutput({name, "_done_pulse"}, int'(done_w[k]), 0);
    checkOutput({name, "_stim_hold"},  int'(vec[k]),    nvec - 1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      ymode[k]   = 2'd0;
      zmode[k]   = 2'd0;
      yflip[k]   = 16'h0000;
      zflip[k]   = 16'h0000;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle(0, "rst_def");
    checkIdle(1, "rst_stop");
    checkIdle(2, "rst_fast");
    rst_n = 1'b1;

    runCase(0, "clean");

    zmode[0] = 2'd1;
    runCase(0, "z0");
    checkOutput("z0_map_const", int'(map_w[0]), 16'h050F);
    checkOutput("z0_cnt_const", int'(cnt_w[0]), 6);
    zmode[0] = 2'd0;

    zmode[1] = 2'd1;
    runCase(1, "z0_stop");
    checkOutput("z0_stop_map_const", int'(map_w[1]), 16'h0001);

    zmode[1] = 2'd0;
    runCase(1, "b2b");

    ymode[2] = 2'd2;
    runCase(2, "y1_fast");
    checkOutput("y1_fast_map_const", int'(map_w[2]), 16'h00CF);
    ymode[2] = 2'd0;

    for (int r = 0; r < 8; r++) begin
      int k;
      k        = int'($urandom_range(0, 2));
      ymode[k] = 2'd0;
      zmode[k] = 2'd0;
      yflip[k] = 16'($urandom & $urandom & $urandom);
      zflip[k] = 16'($urandom & $urandom & $urandom);
      runCase(k, $sformatf("rnd%0d", r));
      yflip[k] = 16'h0000;
      zflip[k] = 16'h0000;
    end

    // Mid-run start must be ignored; then an async reset at vector 7.
    yflip[0] = 16'h0001;
    applyStimulus(0);
    repeat (4) @(negedge clk);
    applyStimulus(0);
    repeat (8) @(negedge clk);
    checkOutput("mid_stim7", int'(vec[0]), 7);
    checkOutput("mid_cnt",   int'(cnt_w[0]), 1);
    rst_n = 1'b0;
    #1;
    checkIdle(0, "rst_mid");
    @(negedge clk);
    rst_n    = 1'b1;
    yflip[0] = 16'h0000;
    runCase(0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
